seven_seg_scan_ctrl: RTL and testbench
======================================

# seven_seg_scan_ctrl

Parametrised, time-multiplexed seven-segment scan controller for the candy vending display. It converts the binary `sum` (money inserted) to BCD with a sequential double-dabble engine and shows `candy_sum` on the top digit. It scans `NUM_DIGITS` common-anode columns at a configurable refresh rate and feeds `data_out` to the downstream BCD-to-segment decoder. It generalises the fixed 8-column selector to any digit count and sum width. It adds frame-synchronous, tear-free display updates.

## Interface
- `NUM_DIGITS`, 8: number of display columns; must be ≥ `SUM_DIGITS`+1.
- `SUM_W`, 8: width of `sum`.
- `SUM_DIGITS`, 3: number of BCD digits for `sum`; must satisfy 10^`SUM_DIGITS` > 2^`SUM_W`.
- `CANDY_W`, 3: width of `candy_sum`; must be ≤ 3 so the value fits one decimal digit.
- `SCAN_DIV`, 50000: clocks each column stays active; must be ≥ `SUM_W`+2.
- `clk` input 1: system clock; all logic is on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `sum` input `SUM_W`: binary amount to display.
- `candy_sum` input `CANDY_W`: candy count to display.
- `data_out` output 4: BCD nibble for the active column. 4'hF means blank.
- `display_column` output `NUM_DIGITS`: active-low one-hot column enable.

## Operation
- **Prescaler.** `pre_cnt` counts 0..`SCAN_DIV`-1 and wraps. `tick` is asserted when `pre_cnt` = `SCAN_DIV`-1.
- **Digit index.** `dig_idx` advances on `tick`, from 0 to `NUM_DIGITS`-1, then wraps to 0. `frame_start` = `tick` AND `dig_idx` = `NUM_DIGITS`-1.
- **Digit map.**
  - Digits 0..`SUM_DIGITS`-1 are the BCD digits of `sum`, ones first.
  - Digit `NUM_DIGITS`-1 is `candy_sum`, zero-extended to 4 bits.
  - All other digits are unused. For an unused digit, `display_column` is all ones and `data_out` is 4'hF.
- **Converter FSM.**
  - IDLE: when `frame_start` is asserted or `init_pend` is set, capture `sum` and `candy_sum`, clear the BCD register, clear `init_pend`, go to SHIFT.
  - SHIFT: run one double-dabble step per cycle, for `SUM_W` cycles. Each step adds 3 to every BCD nibble ≥ 5, then shifts left one bit. After the last step, go to COMMIT.
  - COMMIT: load the display register (BCD digits plus the captured candy value) in a single cycle, then go to IDLE.
- **`init_pend`.** Set by reset, so the first conversion starts on the first clock after reset is released.
- **Output drive.**
  - `display_column` = ~(1 << `dig_idx`) when the digit is enabled, all ones otherwise.
  - `data_out` = display register nibble at `dig_idx`, or 4'hF when blanked.
  - Both outputs are registered: they update one cycle after `dig_idx` changes.
- **Simultaneous events.** A `frame_start` while the FSM is not IDLE is ignored. This cannot happen when `SCAN_DIV` ≥ `SUM_W`+2.
- **Input changes.** `sum` and `candy_sum` changes during SHIFT have no effect. Values are captured only in IDLE.

## Timing
- **Reset values.**
  - `data_out` = 4'h0.
  - `display_column` = all ones.
  - `dig_idx`, `pre_cnt` = 0.
  - Display register = 0.
  - FSM = IDLE, `init_pend` = 1.
- **Reset assertion.** Asynchronous: outputs take their reset values immediately, including mid-scan and mid-conversion.
- **Conversion latency.** From capture to display-register update is `SUM_W`+1 cycles (`SUM_W` SHIFT cycles plus COMMIT).
- **Input-to-display latency.** From a `sum` change to its appearance is at most one frame (`NUM_DIGITS`×`SCAN_DIV` cycles) plus `SUM_W`+2 cycles.
- **Dwell and refresh.** Each column is held for exactly `SCAN_DIV` cycles. Frame period is `NUM_DIGITS`×`SCAN_DIV` cycles.
- **Stale window.** Digit 0 shows the previous frame's value for its first `SUM_W`+2 cycles.

## Configuration
- **`SEVEN_SEG_LZB_EN` defined:** leading-zero blanking is applied to the sum digits.
  - A sum digit k ≥ 1 is blanked when it and every higher sum digit are zero.
  - Digit 0 is never blanked.
  - The candy digit is never blanked.
- **Undefined:** all sum digits are always enabled, and zeros are displayed.

## Test plan
All scenarios use `SCAN_DIV`=4, `NUM_DIGITS`=8, `SUM_W`=8, `SUM_DIGITS`=3.
- **Reset.** Hold `reset`=0 → `display_column`=8'hFF and `data_out`=0. Release → first conversion starts next cycle.
- **Scan order.** Run 2 frames → `display_column` sequence is FE, FD, FB, then FF ×4 (digits 3..6 unused), then 7F. Each value is held 4 cycles, and the sequence wraps to FE.
- **Conversion.** `sum`=237, `candy_sum`=5 → `data_out` is 7, 3, 2 on columns FE/FD/FB and 5 on 7F. Digits 3..6 give 4'hF.
- **Leading-zero blanking.** `sum`=5 with `SEVEN_SEG_LZB_EN` → digits 1..2 have `display_column`=FF and `data_out`=F. Without the macro → `data_out`=0 on FD and FB. `sum`=0 → digit 0 shows 0 in both builds.
- **Mid-frame change.** Change `sum` 99→200 mid-frame → the display keeps 9,9,0 until the next `frame_start`+9 cycles, then shows 0,0,2.
- **Reset mid-scan.** Assert `reset` while `dig_idx`=2 and the FSM is in SHIFT → `display_column`=FF in the same cycle. After release, scanning restarts at FE, and the value is reconverted with no partial BCD ever displayed.

Source files
------------

// File: rtl/seven_seg_scan_ctrl.sv
// Seven-segment scan controller: double-dabble sum->BCD, frame-synchronous display update; SEVEN_SEG_LZB_EN enables leading-zero blanking.
// Latency: capture to display register SUM_W+1 cycles; outputs registered one cycle behind dig_idx.
// Backpressure: none; free-running scan, inputs sampled only when the converter is idle.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int SUM_W      = 8,
  parameter int SUM_DIGITS = 3,
  parameter int CANDY_W    = 3,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SUM_W-1:0]      sum,
  input  logic [CANDY_W-1:0]    candy_sum,
  output logic [3:0]            data_out,
  output logic [NUM_DIGITS-1:0] display_column
);
  localparam int PRE_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int STEP_W = $clog2(SUM_W + 1);
  localparam int BCD_W  = 4 * SUM_DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  logic [PRE_W-1:0]      pre_cnt;
  logic [IDX_W-1:0]      dig_idx;
  logic                  tick;
  logic                  frame_start;
  state_t                state;
  logic                  init_pend;
  logic [SUM_W-1:0]      shift_reg;
  logic [CANDY_W-1:0]    cap_candy;
  logic [CANDY_W-1:0]    disp_candy;
  logic [BCD_W-1:0]      bcd;
  logic [BCD_W-1:0]      bcd_adj;
  logic [BCD_W-1:0]      disp_bcd;
  logic [STEP_W-1:0]     step_cnt;
  logic [3:0]            dig_val [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] dig_en;

  assign tick        = (pre_cnt == PRE_W'(SCAN_DIV - 1));
  assign frame_start = tick && (dig_idx == IDX_W'(NUM_DIGITS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt <= '0;
      dig_idx <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
      if (tick)
        dig_idx <= (dig_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : dig_idx + IDX_W'(1);
    end
  end

  always_comb begin
    bcd_adj = bcd;
    for (int k = 0; k < SUM_DIGITS; k++)
      if (bcd[4*k +: 4] >= 4'd5)
        bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
  end

  // Display registers only change in COMMIT, so a column never shows a half-converted value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      init_pend  <= 1'b1;
      shift_reg  <= '0;
      cap_candy  <= '0;
      bcd        <= '0;
      step_cnt   <= '0;
      disp_bcd   <= '0;
      disp_candy <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (frame_start || init_pend) begin
            shift_reg <= sum;
            cap_candy <= candy_sum;
            bcd       <= '0;
            step_cnt  <= '0;
            init_pend <= 1'b0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          bcd       <= BCD_W'({bcd_adj, shift_reg[SUM_W-1]});
          shift_reg <= shift_reg << 1;
          step_cnt  <= step_cnt + STEP_W'(1);
          if (step_cnt == STEP_W'(SUM_W - 1))
            state <= COMMIT;
        end
        COMMIT: begin
          disp_bcd   <= bcd;
          disp_candy <= cap_candy;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_DIGITS; k++) begin
      dig_val[k] = 4'hF;
      dig_en[k]  = 1'b0;
    end
    for (int k = 0; k < SUM_DIGITS; k++) begin
      dig_val[k] = disp_bcd[4*k +: 4];
      dig_en[k]  = 1'b1;
    end
    dig_val[NUM_DIGITS-1] = 4'(disp_candy);
    dig_en[NUM_DIGITS-1]  = 1'b1;
`ifdef SEVEN_SEG_LZB_EN
    begin
      logic lz;
      lz = 1'b1;
      // Walk down from the top sum digit; blank while everything above is zero.
      for (int k = SUM_DIGITS - 1; k >= 1; k--) begin
        lz = lz && (disp_bcd[4*k +: 4] == 4'd0);
        if (lz)
          dig_en[k] = 1'b0;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out       <= 4'h0;
      display_column <= '1;
    end else if (dig_en[dig_idx]) begin
      data_out       <= dig_val[dig_idx];
      display_column <= ~(NUM_DIGITS'(1) << dig_idx);
    end else begin
      data_out       <= 4'hF;
      display_column <= '1;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: vector table, hand-written timing corners, randomized run against a decimal-arithmetic model.
module tb_seven_seg_scan_ctrl;
  localparam int ND    = 8;
  localparam int SW    = 8;
  localparam int SD    = 3;
  localparam int CW    = 3;
  localparam int DIV   = 4;
  localparam int FRAME = ND * DIV;
`ifdef SEVEN_SEG_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif
  localparam logic [3:0] Z = LZB ? 4'hF : 4'h0;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [SW-1:0] sum = '0;
  logic [CW-1:0] candy_sum = '0;
  logic [3:0]    data_out;
  logic [ND-1:0] display_column;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS(ND), .SUM_W(SW), .SUM_DIGITS(SD), .CANDY_W(CW), .SCAN_DIV(DIV)
  ) dut (
    .clk(clk), .reset(reset), .sum(sum), .candy_sum(candy_sum),
    .data_out(data_out), .display_column(display_column)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n = 0;
  int shown_sum = 0;
  int shown_candy = 0;
  int q_sum[$];
  int q_candy[$];
  int q_at[$];

  typedef struct {
    int s;
    int c;
    logic [3:0] e0, e1, e2;
  } vec_t;
  vec_t tv [7];
  logic [ND-1:0] col_tab [ND];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at edge %0d: got %0h, want %0h", name, n, act, exp);
    end
  endtask

  function automatic int pow10(input int d);
    int p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [3:0] model_nib(input int d, input int s, input int c);
    if (d == ND - 1) return 4'(c);
    if (d >= SD) return 4'hF;
    if (LZB && d >= 1 && s < pow10(d)) return 4'hF;
    return 4'((s / pow10(d)) % 10);
  endfunction

  task automatic model_reset();
    n = 0;
    shown_sum = 0;
    shown_candy = 0;
    q_sum.delete();
    q_candy.delete();
    q_at.delete();
  endtask

  // Captures happen on the first edge after reset and on every frame boundary;
  // a capture becomes visible on the outputs SW+2 edges later.
  task automatic step(input bit chk);
    int d;
    logic [3:0] nib;
    logic [ND-1:0] col;
    @(posedge clk);
    n++;
    if (n == 1 || n % FRAME == 0) begin
      q_sum.push_back(int'(sum));
      q_candy.push_back(int'(candy_sum));
      q_at.push_back(n + SW + 2);
    end
    while (q_at.size() > 0 && q_at[0] <= n) begin
      shown_sum = q_sum.pop_front();
      shown_candy = q_candy.pop_front();
      void'(q_at.pop_front());
    end
    @(negedge clk);
    if (chk) begin
      d = ((n - 1) / DIV) % ND;
      nib = model_nib(d, shown_sum, shown_candy);
      col = (nib == 4'hF) ? '1 : ~(ND'(1) << d);
      check("model_data", 32'(data_out), 32'(nib));
      check("model_col", 32'(display_column), 32'(col));
    end
  endtask

  task automatic do_reset(input int s, input int c);
    reset = 1'b0;
    sum = SW'(s);
    candy_sum = CW'(c);
    model_reset();
    @(negedge clk);
    check("rst_col", 32'(display_column), 32'hFF);
    check("rst_data", 32'(data_out), 32'h0);
    reset = 1'b1;
  endtask

  initial begin
    int d;
    logic [3:0] e;

    tv[0] = '{237, 5, 4'h7, 4'h3, 4'h2};
    tv[1] = '{5,   0, 4'h5, Z,    Z};
    tv[2] = '{0,   7, 4'h0, Z,    Z};
    tv[3] = '{255, 3, 4'h5, 4'h5, 4'h2};
    tv[4] = '{99,  1, 4'h9, 4'h9, Z};
    tv[5] = '{100, 2, 4'h0, 4'h0, 4'h1};
    tv[6] = '{10,  4, 4'h0, 4'h1, Z};
    col_tab = '{8'hFE, 8'hFD, 8'hFB, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7F};

    foreach (tv[i]) begin
      do_reset(tv[i].s, tv[i].c);
      for (int k = 0; k < 2 * FRAME; k++) begin
        step(1'b1);
        d = ((n - 1) / DIV) % ND;
        if (n > FRAME && (n - 1) % DIV == 1) begin
          if (d == 0) e = tv[i].e0;
          else if (d == 1) e = tv[i].e1;
          else if (d == 2) e = tv[i].e2;
          else if (d == ND - 1) e = 4'(tv[i].c);
          else e = 4'hF;
          check("vec_data", 32'(data_out), 32'(e));
        end
        if (i == 0 && n > SW + 2)
          check("scan_col", 32'(display_column), 32'(col_tab[d]));
      end
    end

    // Mid-frame change: the new value waits for the next frame boundary.
    do_reset(99, 1);
    for (int k = 0; k < 110; k++) begin
      if (n == 40) sum = 8'd200;
      step(1'b1);
      case (n)
        66: check("mid_old_d0", 32'(data_out), 32'h9);
        73: check("mid_old_d2", 32'(data_out), 32'(Z));
        74: check("mid_new_d2", 32'(data_out), 32'h2);
        98: check("mid_new_d0", 32'(data_out), 32'h0);
        default: ;
      endcase
    end

    // Reset while scanning digit 2 with the converter mid-shift.
    do_reset(150, 2);
    for (int k = 0; k < 8; k++) step(1'b1);
    #2 reset = 1'b0;
    #1;
    check("async_col", 32'(display_column), 32'hFF);
    check("async_data", 32'(data_out), 32'h0);
    model_reset();
    sum = 8'd61;
    candy_sum = 3'd6;
    @(negedge clk);
    check("held_col", 32'(display_column), 32'hFF);
    reset = 1'b1;
    step(1'b1);
    check("restart_col", 32'(display_column), 32'hFE);
    check("restart_data", 32'(data_out), 32'h0);
    for (int k = 0; k < 2 * FRAME; k++) step(1'b1);

    do_reset(int'($urandom_range(255)), int'($urandom_range(7)));
    for (int k = 0; k < 1200; k++) begin
      if ($urandom_range(7) == 0) sum = SW'($urandom_range(255));
      if ($urandom_range(15) == 0) candy_sum = CW'($urandom_range(7));
      step(1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
